// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with single-cycle logic/arith ops and iterative MUL/DIV/MOD
module seq_alu #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             zf
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state, nxt;
  logic [3:0] op_r;
  logic [WIDTH-1:0] ra, rb, acc, res, mul_n, rem_n, q_n;
  logic [WIDTH:0] t;
  logic [CW-1:0] cnt;
  logic accept, last, ge, cmp, iter_op;
  assign accept = state == IDLE && start;
  assign iter_op = op >= 4'd13;
  assign last = cnt == CW'(WIDTH - 1);
  assign busy = state != IDLE;
  assign done = state == FIN;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    nxt = state == IDLE ? (start ? (iter_op ? RUN : FIN) : IDLE) :
          state == RUN  ? (last ? FIN : RUN) : IDLE;
  end
  // MUL: acc accumulates, ra multiplicand shifts left, rb multiplier shifts right
  // DIV/MOD: acc is the partial remainder, ra shifts dividend out and quotient in, rb divisor
  always_comb begin
    mul_n = acc + (rb[0] ? ra : '0);
    t = {acc, ra[WIDTH-1]};
    ge = t >= {1'b0, rb};
    rem_n = ge ? WIDTH'(t - {1'b0, rb}) : t[WIDTH-1:0];
    q_n = {ra[WIDTH-2:0], ge};
  end
  always_comb begin
    res = '0;
    cmp = 1'b0;
    case (op)
      4'd0:  res = ina & inb;
      4'd1:  res = ina | inb;
      4'd2:  res = ina ^ inb;
      4'd3:  res = ina + inb;
      4'd4:  res = ina > inb ? ina - inb : inb - ina;
      4'd5:  res = ina + WIDTH'(1);
      4'd6:  res = ina - WIDTH'(1);
      4'd7:  cmp = ina == inb;
      4'd8:  cmp = ina > inb;
      4'd9:  cmp = ina < inb;
      4'd10: res = ina;
      4'd11: res = 32'(inb) >= WIDTH ? '0 : ina << inb;
      4'd12: res = 32'(inb) >= WIDTH ? '0 : ina >> inb;
      default: res = '0;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      op_r <= '0;
      ra <= '0;
      rb <= '0;
      acc <= '0;
      cnt <= '0;
      out <= '0;
      zf <= 1'b0;
    end else if (accept) begin
      op_r <= op;
      ra <= ina;
      rb <= inb;
      acc <= '0;
      cnt <= '0;
      if (!iter_op) begin
        out <= (op >= 4'd7 && op <= 4'd9) ? out : res;
        zf <= (op >= 4'd7 && op <= 4'd9) ? cmp : res == '0;
      end
    end else if (state == RUN) begin
      cnt <= cnt + CW'(1);
      acc <= op_r == 4'd13 ? mul_n : rem_n;
      ra <= op_r == 4'd13 ? ra << 1 : q_n;
      rb <= op_r == 4'd13 ? rb >> 1 : rb;
      // a zero divisor naturally yields all-ones quotient and remainder == dividend
      if (last) begin
        out <= op_r == 4'd13 ? mul_n : op_r == 4'd14 ? q_n : rem_n;
        zf <= op_r == 4'd13 ? mul_n == '0 : (rb == '0 || rem_n == '0);
      end
    end
endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 5, operand/result width in bits; legal range 2..16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset; clears all state immediately.
REQ-004 start  input  1  request strobe; sampled on rising clk edge.
REQ-005 op  input  4  operation code, sampled with start.
REQ-006 ina  input  WIDTH  operand A, sampled with start.
REQ-007 inb  input  WIDTH  operand B, sampled with start.
REQ-008 busy  output  1  high while an accepted operation is in progress.
REQ-009 done  output  1  one-cycle pulse, high in the cycle out/zf first show a new result.
REQ-010 out  output  WIDTH  registered result; holds until the next done.
REQ-011 zf  output  1  registered flag; holds until the next done.

Function
REQ-012 Op codes: 0 AND, 1 OR, 2 XOR, 3 ADD, 4 SUB, 5 INC, 6 DEC, 7 EQ, 8 GT, 9 LT, 10 PASS, 11 SHL, 12 SHR, 13 MUL, 14 DIV, 15 MOD.
REQ-013 Operands and op are latched into internal registers on accept; later input changes do not affect the operation in flight.
REQ-014 State machine: IDLE, RUN, FIN; reset state IDLE.
REQ-015 IDLE: start=1 accepts; ops 0-12 go to FIN; ops 13-15 go to RUN.
REQ-016 IDLE: start=0 stays in IDLE with busy=0.
REQ-017 RUN: one iteration per cycle for exactly WIDTH cycles, then FIN; busy=1 throughout.
REQ-018 FIN: out/zf update on entry with done=1 for that cycle; next state IDLE; busy=1 in FIN.
REQ-019 Latency, start edge to done high: 1 cycle for ops 0-12; WIDTH+1 cycles for ops 13-15.
REQ-020 start while busy=1 is ignored, not queued, and does not alter the operation in flight.
REQ-021 Back-to-back: start is accepted again in the cycle after done (IDLE); max throughput is one single-cycle op every 2 cycles.
REQ-022 ADD, INC, DEC: modulo 2^WIDTH (20+15 -> 3 at WIDTH=5; DEC 0 -> all ones); no carry output.
REQ-023 SUB: absolute difference |ina-inb|; never wraps.
REQ-024 EQ: zf=(ina==inb). GT: zf=(ina>inb). LT: zf=(ina<inb). All unsigned; out unchanged from previous value.
REQ-025 AND, OR, XOR, ADD, SUB, INC, DEC, PASS, SHL, SHR, MUL: zf=1 iff the WIDTH-bit result is zero, else 0.
REQ-026 SHL/SHR: logical shift of ina by inb; inb>=WIDTH gives 0.
REQ-027 MUL: iterative shift-add, unsigned; out = low WIDTH bits of product; zf per REQ-025.
REQ-028 DIV/MOD: iterative restoring division, unsigned; DIV out=quotient, MOD out=remainder; zf=1 iff remainder is zero.
REQ-029 Divide by zero (inb=0, DIV or MOD): still takes WIDTH+1 cycles; DIV out=all ones, MOD out=ina, zf=1.
REQ-030 done is never high in two consecutive cycles; done and an accept never occur in the same cycle.

Reset
REQ-031 rst=1 forces IDLE, busy=0, done=0, out=0, zf=0, and clears the internal operand and iteration registers, asynchronously.
REQ-032 rst asserted mid-RUN aborts the operation; no done pulse follows; out/zf read 0.
REQ-033 start high in the first edge after rst deasserts is accepted normally.

Verification (WIDTH=5)
REQ-034 ADD ina=20 inb=15 -> one cycle later done=1, out=3, zf=0; SUB ina=3 inb=9 -> out=6.
REQ-035 MOD ina=14 inb=3 -> busy for 6 cycles, done in cycle 6, out=2, zf=0; MOD 15,3 -> out=0, zf=1.
REQ-036 DIV ina=9 inb=0 -> done after 6 cycles, out=31, zf=1; MUL 7,6 -> out=10.
REQ-037 MUL 3,4 started, then start with ADD 1,1 during RUN -> ignored, single done, out=12.
REQ-038 rst pulse during cycle 3 of DIV 30,7 -> out=0, zf=0, busy=0, no done; a subsequent EQ 5,5 -> zf=1 after 1 cycle.
REQ-039 GT 9,4 -> zf=1; LT 9,4 -> zf=0; SHL 1,7 -> out=0, zf=1.
